// File: rtl/alu_issue_stage.sv
// alu_issue_stage
//   Issue front end for a combinational RV32I ALU. Decodes OP / OP-IMM
//   instructions into ALU control and operands (S1), then registers the ALU
//   response into a backpressured output stage (S2). The ALU itself is an
//   external instance wired to the alu_* ports.
//
//   Optional build macro: ALU_ISSUE_PERF_EN adds perf_issued / perf_illegal
//   counters (out handshakes, and illegal ops among them).
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              instruction handshake
//   in_instr, in_rs1, in_rs2       instruction word and register operands
//   alu_a, alu_b, alu_ctl          drive to ALU (held in S1)
//   alu_out, alu_zero, alu_ovf     ALU response
//   out_valid/out_ready            result handshake
//   out_result/zero/ovf/rd/illegal registered result fields
//   perf_issued, perf_illegal      (ALU_ISSUE_PERF_EN only) 32-bit counters
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_rs1,
  input  logic [DATA_WIDTH-1:0] in_rs2,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_ctl,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_zero,
  input  logic                  alu_ovf,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_zero,
  output logic                  out_ovf,
  output logic [4:0]            out_rd,
  output logic                  out_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_illegal
`endif
);

  localparam logic [3:0] CTL_AND  = 4'd0;
  localparam logic [3:0] CTL_OR   = 4'd1;
  localparam logic [3:0] CTL_XOR  = 4'd2;
  localparam logic [3:0] CTL_ADD  = 4'd3;
  localparam logic [3:0] CTL_SUB  = 4'd4;
  localparam logic [3:0] CTL_SLL  = 4'd5;
  localparam logic [3:0] CTL_SRL  = 4'd6;
  localparam logic [3:0] CTL_SRA  = 4'd7;
  localparam logic [3:0] CTL_SLT  = 4'd8;
  localparam logic [3:0] CTL_IDLE = 4'd15;

  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_IMM = 7'b0010011;

  // S1 (decode) state
  logic                  r_s1_valid;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [3:0]            r_alu_ctl;
  logic [4:0]            r_s1_rd;
  logic                  r_s1_illegal;

  // S2 (result) state
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_result;
  logic                  r_out_zero;
  logic                  r_out_ovf;
  logic [4:0]            r_out_rd;
  logic                  r_out_illegal;

  // handshake
  logic w_s2_free, w_s1_adv, w_in_fire;

  assign w_s2_free = !r_out_valid | out_ready;
  assign w_s1_adv  = r_s1_valid & w_s2_free;
  assign in_ready  = !r_s1_valid | w_s2_free;
  assign w_in_fire = in_valid & in_ready;

  // decode
  logic [6:0]            w_opc, w_f7;
  logic [2:0]            w_f3;
  logic                  w_is_op, w_is_imm, w_f7_zero, w_f7_alt;
  logic                  w_legal, w_shift;
  logic [3:0]            w_ctl;
  logic [DATA_WIDTH-1:0] w_a, w_b, w_imm, w_shamt;
  logic                  w_unused;

  assign w_opc     = in_instr[6:0];
  assign w_f3      = in_instr[14:12];
  assign w_f7      = in_instr[31:25];
  assign w_is_op   = (w_opc == OPC_OP);
  assign w_is_imm  = (w_opc == OPC_IMM);
  assign w_f7_zero = (w_f7 == 7'b0000000);
  assign w_f7_alt  = (w_f7 == 7'b0100000);
  assign w_imm     = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
  // Shift amount is only ever 5 bits; upper operand bits are forced to 0.
  assign w_shamt   = w_is_op ? DATA_WIDTH'(in_rs2[4:0]) : DATA_WIDTH'(in_instr[24:20]);
  // rs1 field is resolved by the register-read stage; not needed here.
  assign w_unused  = ^in_instr[19:15];

  always_comb begin
    w_legal = 1'b0;
    w_ctl   = CTL_IDLE;
    if (w_is_op || w_is_imm) begin
      case (w_f3)
        3'b000: begin
          // ADDI's immediate occupies funct7, so only OP can select SUB.
          if (w_is_imm || w_f7_zero) begin
            w_legal = 1'b1; w_ctl = CTL_ADD;
          end else if (w_f7_alt) begin
            w_legal = 1'b1; w_ctl = CTL_SUB;
          end
        end
        3'b001: if (w_f7_zero) begin w_legal = 1'b1; w_ctl = CTL_SLL; end
        3'b010: if (w_is_imm || w_f7_zero) begin w_legal = 1'b1; w_ctl = CTL_SLT; end
        3'b100: if (w_is_imm || w_f7_zero) begin w_legal = 1'b1; w_ctl = CTL_XOR; end
        3'b101: begin
          if (w_f7_zero) begin
            w_legal = 1'b1; w_ctl = CTL_SRL;
          end else if (w_f7_alt) begin
            w_legal = 1'b1; w_ctl = CTL_SRA;
          end
        end
        3'b110: if (w_is_imm || w_f7_zero) begin w_legal = 1'b1; w_ctl = CTL_OR; end
        3'b111: if (w_is_imm || w_f7_zero) begin w_legal = 1'b1; w_ctl = CTL_AND; end
        default: w_legal = 1'b0; // SLTU / SLTIU unsupported
      endcase
    end
  end

  assign w_shift = (w_ctl == CTL_SLL) || (w_ctl == CTL_SRL) || (w_ctl == CTL_SRA);

  always_comb begin
    w_a = '0;
    w_b = '0;
    if (w_legal) begin
      w_a = in_rs1;
      if (w_shift)     w_b = w_shamt;
      else if (w_is_op) w_b = in_rs2;
      else             w_b = w_imm;
    end
  end

  // S1: load on input transfer; return to idle drive when drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctl    <= CTL_IDLE;
      r_s1_rd      <= '0;
      r_s1_illegal <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid   <= 1'b1;
      r_alu_a      <= w_a;
      r_alu_b      <= w_b;
      r_alu_ctl    <= w_ctl;
      r_s1_rd      <= in_instr[11:7];
      r_s1_illegal <= !w_legal;
    end else if (w_s1_adv) begin
      r_s1_valid   <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_ctl    <= CTL_IDLE;
      r_s1_rd      <= '0;
      r_s1_illegal <= 1'b0;
    end
  end

  // S2: capture ALU response; illegal ops report a clean zero result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_result  <= '0;
      r_out_zero    <= 1'b0;
      r_out_ovf     <= 1'b0;
      r_out_rd      <= '0;
      r_out_illegal <= 1'b0;
    end else if (w_s1_adv) begin
      r_out_valid   <= 1'b1;
      r_out_result  <= r_s1_illegal ? '0 : alu_out;
      r_out_zero    <= r_s1_illegal ? 1'b1 : alu_zero;
      r_out_ovf     <= r_s1_illegal ? 1'b0 : alu_ovf;
      r_out_rd      <= r_s1_rd;
      r_out_illegal <= r_s1_illegal;
    end else if (out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] r_perf_issued, r_perf_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_issued  <= '0;
      r_perf_illegal <= '0;
    end else if (r_out_valid && out_ready) begin
      r_perf_issued <= r_perf_issued + 32'd1;
      if (r_out_illegal) r_perf_illegal <= r_perf_illegal + 32'd1;
    end
  end

  assign perf_issued  = r_perf_issued;
  assign perf_illegal = r_perf_illegal;
`endif

  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_ctl     = r_alu_ctl;
  assign out_valid   = r_out_valid;
  assign out_result  = r_out_result;
  assign out_zero    = r_out_zero;
  assign out_ovf     = r_out_ovf;
  assign out_rd      = r_out_rd;
  assign out_illegal = r_out_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed decode/result cases, backpressure,
// reset flush, and a randomized stream scored against an instruction-level
// reference model. A behavioural ALU closes the alu_* loop.
module tb_alu_issue_stage;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_rs1, in_rs2;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_ctl;
  logic        alu_zero, alu_ovf;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_ovf, out_illegal;
  logic [4:0]  out_rd;

  int errors = 0;
  int checks = 0;

  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl),
    .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_ovf(out_ovf), .out_rd(out_rd),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU
  logic [31:0] sum_t, dif_t;
  always_comb begin
    sum_t   = alu_a + alu_b;
    dif_t   = alu_a - alu_b;
    alu_out = 32'd0;
    alu_ovf = 1'b0;
    case (alu_ctl)
      4'd0: alu_out = alu_a & alu_b;
      4'd1: alu_out = alu_a | alu_b;
      4'd2: alu_out = alu_a ^ alu_b;
      4'd3: begin alu_out = sum_t; alu_ovf = (alu_a[31] == alu_b[31]) && (sum_t[31] != alu_a[31]); end
      4'd4: begin alu_out = dif_t; alu_ovf = (alu_a[31] != alu_b[31]) && (dif_t[31] != alu_a[31]); end
      4'd5: alu_out = alu_a << alu_b[4:0];
      4'd6: alu_out = alu_a >> alu_b[4:0];
      4'd7: alu_out = $signed(alu_a) >>> alu_b[4:0];
      4'd8: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default: alu_out = 32'd0;
    endcase
  end
  assign alu_zero = (alu_out == 32'd0);

  typedef struct packed {
    logic        illegal;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic [4:0]  rd;
  } exp_t;

  // Instruction-level reference: what the op computes, straight from RV32I.
  function automatic exp_t ref_exec(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] r2);
    exp_t        e;
    logic        is_op, is_imm, ok, v;
    logic [31:0] b, r;
    logic [6:0]  f7;
    logic [4:0]  sh;
    is_op  = (ins[6:0] == 7'h33);
    is_imm = (ins[6:0] == 7'h13);
    f7     = ins[31:25];
    b      = is_op ? r2 : {{20{ins[31]}}, ins[31:20]};
    sh     = is_op ? r2[4:0] : ins[24:20];
    ok = 1'b0; v = 1'b0; r = 32'd0;
    if (is_op || is_imm) begin
      case (ins[14:12])
        3'd0: if (is_op && f7 == 7'h20) begin
                r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); ok = 1'b1;
              end else if (is_imm || f7 == 7'h00) begin
                r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); ok = 1'b1;
              end
        3'd1: if (f7 == 7'h00) begin r = a << sh; ok = 1'b1; end
        3'd2: if (is_imm || f7 == 7'h00) begin r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; ok = 1'b1; end
        3'd4: if (is_imm || f7 == 7'h00) begin r = a ^ b; ok = 1'b1; end
        3'd5: if (f7 == 7'h00) begin r = a >> sh; ok = 1'b1; end
              else if (f7 == 7'h20) begin r = $signed(a) >>> sh; ok = 1'b1; end
        3'd6: if (is_imm || f7 == 7'h00) begin r = a | b; ok = 1'b1; end
        3'd7: if (is_imm || f7 == 7'h00) begin r = a & b; ok = 1'b1; end
        default: ok = 1'b0;
      endcase
    end
    e.illegal = !ok;
    e.result  = ok ? r : 32'd0;
    e.zero    = (e.result == 32'd0);
    e.ovf     = ok & v;
    e.rd      = ins[11:7];
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    int k, m;
    w = $urandom;
    k = $urandom_range(0, 9);
    m = $urandom_range(0, 3);
    if (k < 4) w[6:0] = 7'h33;
    else if (k < 8) w[6:0] = 7'h13;
    if (m < 2) w[31:25] = 7'h00;
    else if (m == 2) w[31:25] = 7'h20;
    return w;
  endfunction

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_rs1 = '0; in_rs2 = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, in_ready, alu_ctl, alu_a, alu_b} !== {1'b0, 1'b1, 4'd15, 32'd0, 32'd0}) begin
      errors++;
      $display("FAIL reset_ctrl: got ov=%0b ir=%0b ctl=%0d a=%h b=%h, want ov=0 ir=1 ctl=15 a=0 b=0",
               out_valid, in_ready, alu_ctl, alu_a, alu_b);
    end
    checks++;
    if ({out_result, out_zero, out_ovf, out_rd, out_illegal} !== 40'd0) begin
      errors++;
      $display("FAIL reset_out: got res=%h z=%0b o=%0b rd=%0d il=%0b, want all 0",
               out_result, out_zero, out_ovf, out_rd, out_illegal);
    end
  endtask

  // Directed single-op table: S1 drive checked one cycle after accept,
  // result checked the cycle after that.
  task automatic test_directed();
    logic [31:0] t_ins [11] = '{32'h002081B3, 32'h402081B3, 32'h002081B3, 32'h002091B3,
                                32'h4040D193, 32'hFFF08193, 32'h0000A183, 32'h0020B1B3,
                                32'h022081B3, 32'h002081B3, 32'h402081B3};
    logic [31:0] t_a   [11] = '{32'd5, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1, 32'h80000000, 32'd1,
                                32'd9, 32'd9, 32'd9, 32'd0, 32'd4};
    logic [31:0] t_b   [11] = '{32'd7, 32'hFFFFFFFF, 32'd1, 32'h24, 32'd0, 32'd0,
                                32'd9, 32'd9, 32'd9, 32'd0, 32'd4};
    logic [3:0]  t_ctl [11] = '{4'd3, 4'd4, 4'd3, 4'd5, 4'd7, 4'd3, 4'd15, 4'd15, 4'd15, 4'd3, 4'd4};
    logic [31:0] t_opb [11] = '{32'd7, 32'hFFFFFFFF, 32'd1, 32'd4, 32'd4, 32'hFFFFFFFF,
                                32'd0, 32'd0, 32'd0, 32'd0, 32'd4};
    logic [31:0] t_res [11] = '{32'd12, 32'h80000000, 32'h80000000, 32'h10, 32'hF8000000, 32'd0,
                                32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic        t_z   [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        t_o   [11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        t_il  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_instr = t_ins[i]; in_rs1 = t_a[i]; in_rs2 = t_b[i]; out_ready = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;
      checks++;
      if ({alu_ctl, alu_b} !== {t_ctl[i], t_opb[i]}) begin
        errors++;
        $display("FAIL dir%0d_drive: got ctl=%0d b=%h, want ctl=%0d b=%h", i, alu_ctl, alu_b, t_ctl[i], t_opb[i]);
      end
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_result, out_zero, out_ovf, out_rd, out_illegal} !==
          {1'b1, t_res[i], t_z[i], t_o[i], 5'd3, t_il[i]}) begin
        errors++;
        $display("FAIL dir%0d_result: got v=%0b res=%h z=%0b o=%0b rd=%0d il=%0b, want v=1 res=%h z=%0b o=%0b rd=3 il=%0b",
                 i, out_valid, out_result, out_zero, out_ovf, out_rd, out_illegal, t_res[i], t_z[i], t_o[i], t_il[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  // Four ADDs with the consumer stalled: two get in, then in_ready drops and
  // everything holds; on release all four drain back-to-back in order.
  task automatic test_back_to_back();
    logic [31:0] got [$];
    int          gcyc [$];
    int          sent, cyc;
    logic [31:0] held_res, held_a;
    sent = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_rs1 = 32'd100; in_rs2 = 32'd0;
    @(posedge clk); #1 sent = 1; in_rs1 = 32'd101; in_rs2 = 32'd3;
    @(posedge clk); #1 sent = 2; in_rs1 = 32'd102; in_rs2 = 32'd6;
    held_res = out_result; held_a = alu_a;
    checks++;
    if ({in_ready, out_valid, out_result} !== {1'b0, 1'b1, 32'd100}) begin
      errors++;
      $display("FAIL bp_full: got ir=%0b ov=%0b res=%0d, want ir=0 ov=1 res=100", in_ready, out_valid, out_result);
    end
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if ({in_ready, out_valid, out_result, alu_a, alu_ctl} !== {1'b0, 1'b1, held_res, held_a, 4'd3}) begin
        errors++;
        $display("FAIL bp_hold: got ir=%0b ov=%0b res=%0d a=%0d ctl=%0d, want ir=0 ov=1 res=%0d a=%0d ctl=3",
                 in_ready, out_valid, out_result, alu_a, alu_ctl, held_res, held_a);
      end
    end
    out_ready = 1'b1;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin got.push_back(out_result); gcyc.push_back(cyc); end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
      if (sent >= 4) in_valid = 1'b0;
      else begin in_rs1 = 32'd100 + 32'(sent); in_rs2 = 32'(sent * 3); end
    end
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL bp_count: got %0d results, want 4", got.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got[i] !== 32'(100 + 4 * i) || gcyc[i] != gcyc[0] + i) begin
          errors++;
          $display("FAIL bp_order%0d: got res=%0d at cyc %0d, want res=%0d at cyc %0d",
                   i, got[i], gcyc[i], 100 + 4 * i, gcyc[0] + i);
        end
      end
    end
  endtask

  // Fill S1 and S2, reset, and confirm nothing stale emerges.
  task automatic test_reset_flush();
    int seen;
    seen = 0;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h002081B3; in_rs1 = 32'd1; in_rs2 = 32'd2;
    @(posedge clk); #1;
    @(posedge clk); #1 in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++;
    if ({out_valid, alu_ctl, in_ready} !== {1'b0, 4'd15, 1'b1}) begin
      errors++;
      $display("FAIL flush_state: got ov=%0b ctl=%0d ir=%0b, want ov=0 ctl=15 ir=1", out_valid, alu_ctl, in_ready);
    end
    out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL flush_stale: got %0d stale results, want 0", seen);
    end
  endtask

  task automatic test_random();
    exp_t        q [$];
    exp_t        e, obs;
    logic        prev_stall;
    exp_t        prev_obs;
    int          drain, bad_hold, bad_cmp;
    bad_hold = 0; bad_cmp = 0; prev_stall = 1'b0; prev_obs = '0;
    in_valid = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (!(in_valid && !in_ready) || c == 0) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = rand_instr(); in_rs1 = rand_opnd(); in_rs2 = rand_opnd();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (c >= 1480) in_valid = 1'b0;
      @(negedge clk);
      obs = '{illegal: out_illegal, result: out_result, zero: out_zero, ovf: out_ovf, rd: out_rd};
      if (prev_stall) begin
        checks++;
        if (!out_valid || obs !== prev_obs) begin
          errors++; bad_hold++;
          if (bad_hold < 5) $display("FAIL rnd_hold: got v=%0b %h, want v=1 %h", out_valid, obs, prev_obs);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_spurious: got result %h, want none", obs);
        end else begin
          e = q.pop_front();
          if (obs !== e) begin
            errors++; bad_cmp++;
            if (bad_cmp < 5) $display("FAIL rnd_result: got %h, want %h", obs, e);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(ref_exec(in_instr, in_rs1, in_rs2));
      prev_stall = out_valid && !out_ready;
      prev_obs = obs;
    end
    drain = 0;
    out_ready = 1'b1;
    while (q.size() != 0 && drain < 20) begin
      @(negedge clk);
      obs = '{illegal: out_illegal, result: out_result, zero: out_zero, ovf: out_ovf, rd: out_rd};
      if (out_valid) begin
        e = q.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL rnd_drain: got %h, want %h", obs, e); end
      end
      drain++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL rnd_lost: got %0d ops undelivered, want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Front end that drives the ALU's a/b/ctl interface and consumes its out/zero/ovf.
- Accepts RV32I OP and OP-IMM instructions with register operands over a valid/ready handshake, and decodes them into ALU control and operands.
- Registers the ALU response into an output stage with backpressure.
- Sits between the register-read stage and writeback. The ALU stays a separate combinational instance wired to the alu_* ports.

Parameters:
- DATA_WIDTH, 32, operand/result width; decode assumes 32 (RV32I immediates, 5-bit shamt).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction/operands valid
- in_ready  out  1  stage can accept
- in_instr  in  32  RV32I instruction word
- in_rs1  in  DATA_WIDTH  rs1 value
- in_rs2  in  DATA_WIDTH  rs2 value
- alu_a  out  DATA_WIDTH  to ALU a
- alu_b  out  DATA_WIDTH  to ALU b
- alu_ctl  out  4  to ALU ctl
- alu_out  in  DATA_WIDTH  from ALU out
- alu_zero  in  1  from ALU zero
- alu_ovf  in  1  from ALU ovf
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  DATA_WIDTH  registered result
- out_zero  out  1  registered zero
- out_ovf  out  1  registered overflow
- out_rd  out  5  instr[11:7] of the op
- out_illegal  out  1  op was not decodable

Behaviour:
- Two register stages:
  - S1 (decode): holds alu_a, alu_b, alu_ctl, rd, illegal, s1_valid.
  - S2 (result): holds the out_* fields.
- Latency: 2 cycles from the in handshake to out_valid, with no stall.
- ctl encoding:
  - 0 AND, 1 OR, 2 XOR, 3 ADD, 4 SUB, 5 SLL, 6 SRL, 7 SRA, 8 SLT.
  - 15 is the idle/illegal code; the ALU returns 0 for it.
- Decode, opcode 0110011 (OP), funct7 must be 0000000 except SUB/SRA which use 0100000:
  - funct3 000: ADD(3), or SUB(4) when funct7=0100000.
  - funct3 001: SLL(5).
  - funct3 010: SLT(8).
  - funct3 100: XOR(2).
  - funct3 101: SRL(6), or SRA(7) when funct7=0100000.
  - funct3 110: OR(1).
  - funct3 111: AND(0).
- Decode, opcode 0010011 (OP-IMM): same map with b = sign-extended instr[31:20]. Exceptions:
  - ADDI never selects SUB.
  - SLLI requires instr[31:25]=0000000.
  - SRLI/SRAI select on instr[30]; other instr[31:25] bits must be 0.
- Shift operand: for ctl 5/6/7, alu_b = zero-extended 5-bit shamt (rs2[4:0] or instr[24:20]). Upper bits are forced to 0.
- Illegal cases:
  - Any other opcode, funct3 011 (SLTU/SLTIU), or a bad funct7.
  - Result: illegal=1, alu_ctl=15, alu_a=alu_b=0.
  - The op still flows through with out_result=0, out_zero=1, out_ovf=0, out_illegal=1.
- Handshake rules:
  - s2_free = !out_valid | out_ready
  - s1_adv = s1_valid & s2_free
  - in_ready = !s1_valid | s2_free
  - The input transfer occurs when in_valid & in_ready.
- Stage updates:
  - S2 captures the ALU response and S1 sideband on s1_adv.
  - S1 loads on an input transfer.
  - S1 clears s1_valid on s1_adv when there is no new transfer.
- Throughput: simultaneous S1 advance and input transfer gives 1 op/cycle.
- Stall: while out_valid & !out_ready, all out_* and alu_* are held stable and in_ready deasserts once S1 is full.
- When s1_valid=0, alu_ctl is driven to 15 and alu_a/alu_b to 0.
- Reset: s1_valid=0, out_valid=0, alu_a=alu_b=0, alu_ctl=15, out_result=0, out_zero=0, out_ovf=0, out_rd=0, out_illegal=0. in_ready=1 the cycle after reset.
- Reset mid-operation drops both in-flight ops, with no output handshake.
- in_ready is combinational from out_ready; no path from in_valid to in_ready.

Optional Feature:
- Macro: ALU_ISSUE_PERF_EN.
- Enabled, adds two outputs: perf_issued (32 bits) and perf_illegal (32 bits).
  - perf_issued increments on each out handshake (out_valid & out_ready).
  - perf_illegal increments when that op has out_illegal=1.
  - Both wrap modulo 2^32 and reset to 0.
- Disabled: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- ADD x3,x1,x2 with rs1=5, rs2=7, out_ready=1: alu_ctl=3 at cycle 1; out_result=12, out_rd=3, zero=0 at cycle 2.
- SUB with rs1=0x7FFFFFFF, rs2=0xFFFFFFFF: alu_ctl=4, out_result=0x80000000, out_ovf per ALU; then ADD 0x7FFFFFFF+1 gives out_ovf=1.
- SLL with rs2=0x00000024: alu_b=0x4 (masked), rs1=1 gives result 0x10. SRAI 4 of 0x80000000 gives 0xF8000000. ADDI imm=0xFFF with rs1=1 gives 0, zero=1.
- Illegal cases: opcode 0000011, SLTU, and OP with funct7=0000001 each give out_illegal=1, result=0, alu_ctl=15.
- Backpressure: stream of 4 ADDs with out_ready low for 3 cycles. in_ready drops after 2 accepted ops and outputs stay stable; on release all 4 results appear in order, back-to-back.
- Reset with S1 and S2 full: next cycle out_valid=0, alu_ctl=15, in_ready=1; no stale result ever appears.
